// File: rtl/restoring_divider_4bits_pkg.sv
// div_defs: shared widths, divide-by-zero quotient and FSM encoding for the restoring divider
package div_defs;
    localparam int DIV_WIDTH = 4;
    localparam logic [3:0] DIV_ZERO_Q = 4'b1111;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_e;
endpackage

// File: rtl/subtractor_4bits.sv
// subtractor_4bits: A - B as A + ~B + 1; Cout=1 means no borrow (A >= B)
module subtractor_4bits (
    output logic [3:0] Diff,
    output logic       Cout,
    input  logic [3:0] A,
    input  logic [3:0] B
);
    assign {Cout, Diff} = {1'b0, A} + {1'b0, ~B} + 5'd1;
endmodule

// File: rtl/restoring_divider_4bits.sv
// restoring_divider_4bits: sequential unsigned divider, one quotient bit per clock via subtractor_4bits
module restoring_divider_4bits
    import div_defs::*;
#(
    parameter int         WIDTH  = DIV_WIDTH,
    parameter logic [3:0] ZERO_Q = DIV_ZERO_Q
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       div_by_zero
);
    if (WIDTH != 4) begin : g_width_check
        $error("restoring_divider_4bits supports WIDTH=4 only");
    end
    state_e     state_q, state_d;
    logic [3:0] r_q, r_d, q_q, q_d, d_q, d_d;
    logic [1:0] cnt_q, cnt_d;
    logic       busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic [3:0] quo_q, quo_d, rem_q, rem_d;
    logic [3:0] shifted, diff;
    logic       cout, take;
    assign shifted = {r_q[2:0], q_q[3]};
    subtractor_4bits u_sub (
        .Diff(diff),
        .Cout(cout),
        .A   (shifted),
        .B   (d_q)
    );
    // R[3] set means the 5-bit partial remainder exceeds any 4-bit divisor
    assign take = cout | r_q[3];
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            RUN: begin
                r_d   = take ? diff : shifted;
                q_d   = {q_q[2:0], take};
                cnt_d = cnt_q == 2'd0 ? cnt_q : cnt_q - 2'd1;
                if (cnt_q == 2'd0) begin
                    state_d = FIN;
                    quo_d   = q_d;
                    rem_d   = r_d;
                    dbz_d   = 1'b0;
                end
            end
            FIN: state_d = IDLE;
            default: begin
                state_d = IDLE;
                if (start) begin
                    d_d     = divisor;
                    q_d     = dividend;
                    r_d     = 4'd0;
                    cnt_d   = 2'(WIDTH - 1);
                    state_d = divisor == 4'd0 ? FIN : RUN;
                    if (divisor == 4'd0) begin
                        quo_d = ZERO_Q;
                        rem_d = dividend;
                        dbz_d = 1'b1;
                    end
                end
            end
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == FIN;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= 4'd0;
            q_q     <= 4'd0;
            d_q     <= 4'd0;
            cnt_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= 4'd0;
            rem_q   <= 4'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end
    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_divider_4bits.sv
// tb_restoring_divider_4bits: directed and exhaustive checks of the divider against a cycle-level model
module tb_restoring_divider_4bits;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [3:0] dividend = 4'd0, divisor = 4'd0;
    logic       busy, done, div_by_zero;
    logic [3:0] quotient, remainder;

    restoring_divider_4bits dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, e_acc = -10, e_done = -10, n_acc = 0;
    int p_a = 0, p_b = 0, p_q = 0, p_r = 0, p_z = 0;
    int c_a = 0, c_b = 0, c_q = 0, c_r = 0, c_z = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    // model: accepts start only when idle, results land after 4 steps (or at once for divisor 0)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_acc  = -10;
            e_done = -10;
            c_q = 0; c_r = 0; c_z = 0;
        end else begin
            cyc++;
            if (start && cyc - 1 > e_done) begin
                p_a = int'(dividend);
                p_b = int'(divisor);
                p_z = p_b == 0 ? 1 : 0;
                p_q = p_z == 1 ? 15 : p_a / p_b;
                p_r = p_z == 1 ? p_a : p_a % p_b;
                e_acc  = cyc;
                e_done = cyc + (p_z == 1 ? 0 : 4);
                n_acc++;
            end
            if (cyc == e_done) begin
                c_q = p_q; c_r = p_r; c_z = p_z; c_a = p_a; c_b = p_b;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", int'(busy), int'(cyc >= e_acc && cyc <= e_done));
            chk("done", int'(done), int'(cyc == e_done));
            chk("quotient", int'(quotient), c_q);
            chk("remainder", int'(remainder), c_r);
            chk("div_by_zero", int'(div_by_zero), c_z);
            if (cyc == e_done && c_z == 0) begin
                chk("inv_eq", int'(quotient) * c_b + int'(remainder), c_a);
                chk("inv_lt", int'(int'(remainder) < c_b), 1);
            end
        end
    end

    task automatic run(input int a, input int b);
        int k;
        @(negedge clk);
        dividend = a[3:0];
        divisor  = b[3:0];
        start    = 1'b1;
        k = n_acc;
        for (int i = 0; i < 20 && n_acc == k; i++) begin
            @(posedge clk);
            #1;
        end
        chk("accept", int'(n_acc != k), 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) break;
        end
        chk("done_seen", int'(done), 1);
    endtask

    task automatic lit(input int eq, input int er, input int ez);
        chk("lit_q", int'(quotient), eq);
        chk("lit_r", int'(remainder), er);
        chk("lit_z", int'(div_by_zero), ez);
    endtask

    task automatic div1(input int a, input int b, input int eq, input int er, input int ez);
        run(a, b);
        wait_done();
        lit(eq, er, ez);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q", int'(quotient), 0);
        chk("rst_r", int'(remainder), 0);
        chk("rst_z", int'(div_by_zero), 0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        div1(7, 2, 3, 1, 0);
        div1(12, 3, 4, 0, 0);
        div1(3, 12, 0, 3, 0);
        div1(15, 1, 15, 0, 0);
        div1(15, 15, 1, 0, 0);
        div1(9, 0, 15, 9, 1);
        div1(8, 4, 2, 0, 0);

        run(7, 2);
        @(negedge clk);
        dividend = 4'd14; divisor = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        lit(3, 1, 0);
        dividend = 4'd14; divisor = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        lit(3, 1, 0);

        run(13, 4);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_q", int'(quotient), 0);
        chk("abort_r", int'(remainder), 0);
        chk("abort_z", int'(div_by_zero), 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        div1(13, 4, 3, 1, 0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run(a, b);
        wait_done();
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
